// File: rtl/arm_muldiv_pkg.sv
// rtl/arm_muldiv_pkg.sv - op encoding, FSM states and flag bit positions for arm_muldiv
package arm_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_SMULL = 2'b10,
    OP_UDIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_muldiv_cneg.sv
// rtl/arm_muldiv_cneg.sv - conditional two's-complement negator (arm_cneg)
module arm_cneg #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? ((~din) + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/arm_muldiv.sv
// rtl/arm_muldiv.sv - iterative MUL/UMULL/SMULL/UDIV unit with start/busy/done handshake
// UDIV datapath is present only when ARM_MULDIV_DIV_EN is defined.
module arm_muldiv
  import arm_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  op_e              op_in;
  logic             accept;
  logic             is_smull;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    iter_next, prod_fix;
  logic [WIDTH-1:0] fin_lo, fin_hi;
  logic [3:0]       fin_flags;
  logic             fin_wide;
`ifdef ARM_MULDIV_DIV_EN
  logic [WIDTH:0]   rem_sh, div_diff;
`endif

  assign op_in    = op_e'(op);
  assign is_smull = (op_in == OP_SMULL);
  assign accept   = start && (state_q != ST_RUN);

  arm_cneg #(.W(WIDTH)) u_mag_a (.din(a), .neg(is_smull && a[WIDTH-1]), .dout(a_mag));
  arm_cneg #(.W(WIDTH)) u_mag_b (.din(b), .neg(is_smull && b[WIDTH-1]), .dout(b_mag));
  arm_cneg #(.W(W2))    u_prod  (.din(iter_next), .neg(neg_q), .dout(prod_fix));

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    iter_next = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ARM_MULDIV_DIV_EN
    rem_sh    = acc_q[W2-1:WIDTH-1];
    div_diff  = rem_sh - {1'b0, mcand_q};
    if (op_q == OP_UDIV) begin
      if (div_diff[WIDTH]) iter_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else                 iter_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
`endif
  end

  always_comb begin
    fin_wide  = (op_q == OP_UMULL) || (op_q == OP_SMULL);
    fin_lo    = prod_fix[WIDTH-1:0];
    fin_hi    = (op_q == OP_MUL) ? '0 : prod_fix[W2-1:WIDTH];
    fin_flags = '0;
    fin_flags[FLAG_N] = fin_wide ? fin_hi[WIDTH-1] : fin_lo[WIDTH-1];
    fin_flags[FLAG_Z] = fin_wide ? ({fin_hi, fin_lo} == '0) : (fin_lo == '0);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    err_d   = err_q;

    case (state_q)
      ST_RUN: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_W'(WIDTH)) begin
          state_d = ST_DONE;
          lo_d    = fin_lo;
          hi_d    = fin_hi;
          flags_d = fin_flags;
          err_d   = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    if (accept) begin
      state_d = ST_RUN;
      op_d    = op_in;
      cnt_d   = '0;
      neg_d   = is_smull && (a[WIDTH-1] ^ b[WIDTH-1]);
      mcand_d = a_mag;
      acc_d   = {{WIDTH{1'b0}}, b_mag};
      lo_d    = '0;
      hi_d    = '0;
      flags_d = '0;
      err_d   = 1'b0;
      if (op_in == OP_UDIV) begin
`ifdef ARM_MULDIV_DIV_EN
        mcand_d = b;
        acc_d   = {{WIDTH{1'b0}}, a};
        if (b == '0) begin
          state_d         = ST_DONE;
          lo_d            = '1;
          hi_d            = a;
          flags_d[FLAG_N] = 1'b1;
          err_d           = 1'b1;
        end
`else
        state_d = ST_DONE;
        err_d   = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_arm_muldiv.sv
// tb/tb_arm_muldiv.sv - directed self-checking bench for arm_muldiv (WIDTH=32)
module tb_arm_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result_lo, result_hi;
  logic [3:0]   flags;
  logic         err;

  int   checks = 0;
  int   passes = 0;
  int   edges;
  logic first_busy;
  logic overlap;

  arm_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .flags(flags), .err(err)
  );

  always #5 clk = ~clk;

  task automatic wait_done();
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (busy && done) overlap = 1'b1;
    end
  endtask

  // edges counts clock edges after the accept edge until done is seen
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = ~o;
    edges = 0; first_busy = busy; overlap = busy && done;
    wait_done();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, done, err, flags} !== 7'd0) $display("FAIL reset_ctl: got %b expected 0", {busy, done, err, flags}); else passes++;
    checks++; if (result_lo !== 32'd0) $display("FAIL reset_lo: got %h expected 0", result_lo); else passes++;
    checks++; if (result_hi !== 32'd0) $display("FAIL reset_hi: got %h expected 0", result_hi); else passes++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    run_op(2'b00, 32'd7, 32'd6);
    checks++; if (edges !== 32) $display("FAIL mul_latency: got %0d expected 32", edges); else passes++;
    checks++; if (first_busy !== 1'b1) $display("FAIL mul_busy: got %b expected 1", first_busy); else passes++;
    checks++; if (overlap !== 1'b0) $display("FAIL mul_overlap: got %b expected 0", overlap); else passes++;
    checks++; if (result_lo !== 32'd42) $display("FAIL mul_lo: got %h expected 2a", result_lo); else passes++;
    checks++; if (result_hi !== 32'd0) $display("FAIL mul_hi: got %h expected 0", result_hi); else passes++;
    checks++; if ({flags, err} !== 5'd0) $display("FAIL mul_flags_err: got %b expected 0", {flags, err}); else passes++;
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) $display("FAIL mul_done_pulse: got %b expected 00", {busy, done}); else passes++;
    checks++; if (result_lo !== 32'd42) $display("FAIL mul_hold: got %h expected 2a", result_lo); else passes++;
  endtask

  task automatic test_umull();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (result_hi !== 32'hFFFF_FFFE) $display("FAIL umull_hi: got %h expected fffffffe", result_hi); else passes++;
    checks++; if (result_lo !== 32'h0000_0001) $display("FAIL umull_lo: got %h expected 00000001", result_lo); else passes++;
    checks++; if (flags !== 4'b1000) $display("FAIL umull_flags: got %b expected 1000", flags); else passes++;
  endtask

  task automatic test_smull();
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5);
    checks++; if (result_hi !== 32'hFFFF_FFFF) $display("FAIL smull_neg_hi: got %h expected ffffffff", result_hi); else passes++;
    checks++; if (result_lo !== 32'hFFFF_FFF1) $display("FAIL smull_neg_lo: got %h expected fffffff1", result_lo); else passes++;
    checks++; if (flags !== 4'b1000) $display("FAIL smull_neg_flags: got %b expected 1000", flags); else passes++;
    run_op(2'b10, 32'h8000_0000, 32'h8000_0000);
    checks++; if (result_hi !== 32'h4000_0000) $display("FAIL smull_min_hi: got %h expected 40000000", result_hi); else passes++;
    checks++; if (result_lo !== 32'h0) $display("FAIL smull_min_lo: got %h expected 0", result_lo); else passes++;
    checks++; if (flags !== 4'b0000) $display("FAIL smull_min_flags: got %b expected 0000", flags); else passes++;
  endtask

  task automatic test_udiv();
`ifdef ARM_MULDIV_DIV_EN
    run_op(2'b11, 32'd100, 32'd7);
    checks++; if (edges !== 32) $display("FAIL udiv_latency: got %0d expected 32", edges); else passes++;
    checks++; if (result_lo !== 32'd14) $display("FAIL udiv_quot: got %0d expected 14", result_lo); else passes++;
    checks++; if (result_hi !== 32'd2) $display("FAIL udiv_rem: got %0d expected 2", result_hi); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL udiv_err: got %b expected 0", err); else passes++;
    run_op(2'b11, 32'd5, 32'd0);
    checks++; if (edges !== 0) $display("FAIL dbz_latency: got %0d expected 0", edges); else passes++;
    checks++; if (result_lo !== 32'hFFFF_FFFF) $display("FAIL dbz_lo: got %h expected ffffffff", result_lo); else passes++;
    checks++; if (result_hi !== 32'd5) $display("FAIL dbz_hi: got %h expected 5", result_hi); else passes++;
    checks++; if (err !== 1'b1) $display("FAIL dbz_err: got %b expected 1", err); else passes++;
`else
    run_op(2'b11, 32'd100, 32'd7);
    checks++; if (edges !== 0) $display("FAIL nodiv_latency: got %0d expected 0", edges); else passes++;
    checks++; if ({result_hi, result_lo} !== 64'd0) $display("FAIL nodiv_result: got %h expected 0", {result_hi, result_lo}); else passes++;
    checks++; if ({flags, err} !== 5'b00001) $display("FAIL nodiv_flags_err: got %b expected 00001", {flags, err}); else passes++;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; edges = 0; overlap = 1'b0;
    repeat (10) begin @(posedge clk); #1; edges++; end
    op = 2'b01; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    edges++; start = 1'b0;
    wait_done();
    checks++; if (edges !== 32) $display("FAIL ignore_latency: got %0d expected 32", edges); else passes++;
    checks++; if (result_lo !== 32'd81) $display("FAIL ignore_lo: got %0d expected 81", result_lo); else passes++;
    checks++; if (result_hi !== 32'd0) $display("FAIL ignore_hi: got %h expected 0", result_hi); else passes++;
  endtask

  task automatic test_back_to_back();
    op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    edges = 0; overlap = 1'b0;
    wait_done();
    checks++; if (result_lo !== 32'd6) $display("FAIL b2b_first: got %0d expected 6", result_lo); else passes++;
    a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({busy, done} !== 2'b10) $display("FAIL b2b_no_gap: got %b expected 10", {busy, done}); else passes++;
    checks++; if (result_lo !== 32'd0) $display("FAIL b2b_run_zero: got %h expected 0", result_lo); else passes++;
    edges = 0;
    wait_done();
    checks++; if (edges !== 32) $display("FAIL b2b_latency: got %0d expected 32", edges); else passes++;
    checks++; if (result_lo !== 32'd25) $display("FAIL b2b_second: got %0d expected 25", result_lo); else passes++;
    checks++; if (overlap !== 1'b0) $display("FAIL b2b_overlap: got %b expected 0", overlap); else passes++;
  endtask

  task automatic test_reset_mid();
    int seen;
    op = 2'b00; a = 32'hFFFF; b = 32'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    checks++; if ({busy, done, err, flags} !== 7'd0) $display("FAIL rstmid_ctl: got %b expected 0", {busy, done, err, flags}); else passes++;
    checks++; if ({result_hi, result_lo} !== 64'd0) $display("FAIL rstmid_result: got %h expected 0", {result_hi, result_lo}); else passes++;
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL rstmid_no_done: got %0d active cycles expected 0", seen); else passes++;
    run_op(2'b00, 32'd3, 32'd4);
    checks++; if (result_lo !== 32'd12) $display("FAIL rstmid_after: got %0d expected 12", result_lo); else passes++;
    checks++; if (edges !== 32) $display("FAIL rstmid_latency: got %0d expected 32", edges); else passes++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_umull();
    test_smull();
    test_udiv();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
